// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths and FSM state encoding for the cache controller
package cache_pkg;

  localparam int TAG_W   = 4;
  localparam int IDX_W   = 4;
  localparam int OFF_W   = 2;
  localparam int ADDR_W  = TAG_W + IDX_W + OFF_W;
  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 128;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_e;

  function automatic logic [ADDR_W-1:0] block_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_if.sv
// rtl/cache_if.sv - processor request and memory block bus of the cache controller
interface cache_if;
  import cache_pkg::*;

  logic               cpu_req_valid;
  logic               cpu_req_we;
  logic [ADDR_W-1:0]  cpu_addr;
  logic [WORD_W-1:0]  cpu_wdata;
  logic               cpu_ready;
  logic [WORD_W-1:0]  cpu_rdata;
  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [BLOCK_W-1:0] mem_wdata;
  logic [BLOCK_W-1:0] mem_rdata;
  logic               mem_ack;

  modport master (
    output cpu_req_valid, cpu_req_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req_valid, cpu_req_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_line_store.sv
// rtl/cache_line_store.sv - direct-mapped line arrays, combinational read, synchronous write
module cache_line_store #(
  parameter int LINES   = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 4,
  parameter int BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic               wr_dirty,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_data
);

  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  // Every write leaves the line valid; only the flags are cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-back write-allocate cache controller
module cache_controller
  import cache_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_if.slave           bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int BW = DATA_W * WORDS;

  state_e            state_q;
  logic              refill_q;
  logic              req_we_q;
  logic [TAG_W-1:0]  req_tag_q;
  logic [IDX_W-1:0]  req_idx_q;
  logic [OFF_W-1:0]  req_off_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic              cpu_ready_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [BW-1:0]     mem_wdata_q;
  logic [CNT_W-1:0]  hit_count_q, hit_count_d;
  logic [CNT_W-1:0]  miss_count_q, miss_count_d;

  logic              line_valid, line_dirty;
  logic [TAG_W-1:0]  line_tag;
  logic [BW-1:0]     line_data;
  logic              st_we, st_dirty;
  logic [BW-1:0]     st_data;
  logic              in_compare, hit;

  cache_line_store #(
    .LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W), .BLOCK_W(BW)
  ) u_store (
    .clk(clk), .rst_n(rst_n),
    .rd_idx(req_idx_q), .rd_valid(line_valid), .rd_dirty(line_dirty),
    .rd_tag(line_tag), .rd_data(line_data),
    .wr_en(st_we), .wr_idx(req_idx_q), .wr_dirty(st_dirty),
    .wr_tag(req_tag_q), .wr_data(st_data)
  );

  assign in_compare = (state_q == COMPARE);
  assign hit        = line_valid && (line_tag == req_tag_q);

  // The store is written by a write hit (merge one word) or by a completed fill.
  always_comb begin
    st_we    = 1'b0;
    st_dirty = 1'b1;
    st_data  = line_data;
    st_data[req_off_q*DATA_W +: DATA_W] = req_wdata_q;
    if (in_compare && hit && req_we_q) begin
      st_we = 1'b1;
    end else if ((state_q == ALLOCATE) && bus.mem_ack) begin
      st_we    = 1'b1;
      st_dirty = 1'b0;
      st_data  = bus.mem_rdata;
    end
  end

  // The COMPARE that follows a fill is a re-check, not a new lookup.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (in_compare && !refill_q) begin
      if (hit) begin
        if (hit_count_q != {CNT_W{1'b1}}) hit_count_d = hit_count_q + 1'b1;
      end else if (miss_count_q != {CNT_W{1'b1}}) begin
        miss_count_d = miss_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      refill_q    <= 1'b0;
      req_we_q    <= 1'b0;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_off_q   <= '0;
      req_wdata_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cpu_req_valid) begin
            req_we_q                          <= bus.cpu_req_we;
            {req_tag_q, req_idx_q, req_off_q} <= bus.cpu_addr;
            req_wdata_q                       <= bus.cpu_wdata;
            refill_q                          <= 1'b0;
            state_q                           <= COMPARE;
          end
        end
        COMPARE: begin
          refill_q <= 1'b0;
          if (hit) begin
            cpu_ready_q <= 1'b1;
            if (!req_we_q) cpu_rdata_q <= line_data[req_off_q*DATA_W +: DATA_W];
            state_q <= IDLE;
          end else if (line_valid && line_dirty) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= block_addr(line_tag, req_idx_q);
            mem_wdata_q <= line_data;
            state_q     <= WRITEBACK;
          end else begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= block_addr(req_tag_q, req_idx_q);
            state_q    <= ALLOCATE;
          end
        end
        WRITEBACK: begin
          // mem_req stays high straight into the fill of the same line.
          if (bus.mem_ack) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= block_addr(req_tag_q, req_idx_q);
            state_q    <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            refill_q  <= 1'b1;
            state_q   <= COMPARE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign hit_count     = hit_count_q;
  assign miss_count    = miss_count_q;

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - self-checking bench for cache_controller
module tb_cache_controller;
  import cache_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] hit_count, miss_count;
  int          checks = 0;
  int          errors = 0;

  cache_if bus();

  cache_controller dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // Reference: main memory by block number, plus the cache as plain arrays.
  logic [127:0] ref_mem [256];
  logic         m_valid [16];
  logic         m_dirty [16];
  logic [3:0]   m_tag   [16];
  logic [127:0] m_blk   [16];
  int           m_hits, m_misses;
  logic [31:0]  last_rd;
  logic         e_hit, e_wb;
  logic [9:0]   e_wb_addr, e_fill_addr;
  logic [127:0] e_wb_data;
  logic [31:0]  e_rdata;

  // Observed transaction
  logic         wb_seen, fill_seen, timeout, got_hit;
  logic [9:0]   wb_addr, fill_addr;
  logic [127:0] wb_data;
  logic [31:0]  got_rdata;
  int           got_lat;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
    last_rd  = '0;
  endtask

  task automatic model_step(input logic we, input logic [9:0] a, input logic [31:0] wd);
    logic [3:0] tg, ix;
    int off;
    tg  = a[9:6];
    ix  = a[5:2];
    off = int'(a[1:0]);
    e_hit       = m_valid[ix] && (m_tag[ix] == tg);
    e_wb        = !e_hit && m_valid[ix] && m_dirty[ix];
    e_wb_addr   = {m_tag[ix], ix, 2'b00};
    e_wb_data   = m_blk[ix];
    e_fill_addr = {tg, ix, 2'b00};
    if (e_hit) begin
      m_hits = (m_hits < 65535) ? m_hits + 1 : 65535;
    end else begin
      m_misses = (m_misses < 65535) ? m_misses + 1 : 65535;
      if (e_wb) ref_mem[{m_tag[ix], ix}] = m_blk[ix];
      m_blk[ix]   = ref_mem[{tg, ix}];
      m_valid[ix] = 1'b1;
      m_dirty[ix] = 1'b0;
      m_tag[ix]   = tg;
    end
    if (we) begin
      m_blk[ix][off*32 +: 32] = wd;
      m_dirty[ix] = 1'b1;
    end else begin
      e_rdata = m_blk[ix][off*32 +: 32];
      last_rd = e_rdata;
    end
  endtask

  // Issues one request and plays memory with a fixed ack delay until cpu_ready.
  task automatic run_req(input logic we, input logic [9:0] a, input logic [31:0] wd, input int dly);
    int           wait_cnt;
    logic         busy, r_we;
    logic [9:0]   r_addr;
    logic [127:0] r_wdata;
    wb_seen = 0; fill_seen = 0; timeout = 1; got_lat = 0; busy = 0; wait_cnt = 0;
    r_we = 0; r_addr = '0; r_wdata = '0;
    @(negedge clk);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_we    = we;
    bus.cpu_addr      = a;
    bus.cpu_wdata     = wd;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      bus.cpu_req_valid = 1'b0;
      bus.cpu_wdata     = $urandom;
      got_lat = c + 1;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        busy = 0;
        if (!r_we) chk("req_drop", 160'(bus.mem_req), 160'(0));
      end else if (bus.mem_req) begin
        if (!busy) begin
          busy = 1; wait_cnt = dly;
          r_we = bus.mem_we; r_addr = bus.mem_addr; r_wdata = bus.mem_wdata;
          if (r_we) begin wb_seen = 1; wb_addr = r_addr; wb_data = r_wdata; end
          else begin fill_seen = 1; fill_addr = r_addr; end
        end else begin
          chk("mem_hold", {bus.cpu_ready, bus.mem_we, bus.mem_addr, (r_we ? bus.mem_wdata : r_wdata)},
              {1'b0, r_we, r_addr, r_wdata});
        end
        if (wait_cnt == 0) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = r_we ? 128'($urandom) : ref_mem[r_addr[9:2]];
        end else begin
          wait_cnt--;
        end
      end
      if (bus.cpu_ready) begin
        got_rdata = bus.cpu_rdata;
        timeout = 0;
        break;
      end
    end
    bus.mem_ack = 1'b0;
    got_hit = !wb_seen && !fill_seen;
  endtask

  task automatic check_model(input logic we);
    chk("done", 160'(!timeout), 160'(1));
    chk("hit", 160'(got_hit), 160'(e_hit));
    if (e_hit) chk("hit_latency", 160'(got_lat), 160'(2));
    chk("wb", 160'(wb_seen), 160'(e_wb));
    if (e_wb && wb_seen) begin
      chk("wb_addr", 160'(wb_addr), 160'(e_wb_addr));
      chk("wb_data", 160'(wb_data), 160'(e_wb_data));
    end
    if (!e_hit && fill_seen) chk("fill_addr", 160'(fill_addr), 160'(e_fill_addr));
    chk(we ? "rdata_hold" : "rdata", 160'(got_rdata), 160'(last_rd));
    chk("hit_count", 160'(hit_count), 160'(m_hits));
    chk("miss_count", 160'(miss_count), 160'(m_misses));
  endtask

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wd;
    int          dly;
    logic        hit;
    logic        wb;
    logic [9:0]  wb_addr;
    logic [31:0] wb_w1;
    logic [9:0]  fill_addr;
    logic [31:0] rdata;
    int          hits;
    int          misses;
  } vec_t;

  vec_t vt [7];

  initial begin
    vt[0] = '{1'b0, 10'h045, 32'h0,        0, 1'b0, 1'b0, 10'h000, 32'h0,        10'h044, 32'hDEADBEEF, 0, 1};
    vt[1] = '{1'b0, 10'h046, 32'h0,        0, 1'b1, 1'b0, 10'h000, 32'h0,        10'h000, 32'hCAFE0002, 1, 1};
    vt[2] = '{1'b1, 10'h045, 32'h12345678, 0, 1'b1, 1'b0, 10'h000, 32'h0,        10'h000, 32'hCAFE0002, 2, 1};
    vt[3] = '{1'b0, 10'h245, 32'h0,        7, 1'b0, 1'b1, 10'h044, 32'h12345678, 10'h244, 32'h24450001, 2, 2};
    vt[4] = '{1'b0, 10'h045, 32'h0,        2, 1'b0, 1'b0, 10'h000, 32'h0,        10'h044, 32'h12345678, 2, 3};
    vt[5] = '{1'b1, 10'h047, 32'hA5A5A5A5, 0, 1'b1, 1'b0, 10'h000, 32'h0,        10'h000, 32'h12345678, 3, 3};
    vt[6] = '{1'b0, 10'h047, 32'h0,        0, 1'b1, 1'b0, 10'h000, 32'h0,        10'h000, 32'hA5A5A5A5, 4, 3};

    for (int i = 0; i < 256; i++) ref_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    ref_mem[8'h11] = {32'hCAFE0003, 32'hCAFE0002, 32'hDEADBEEF, 32'hCAFE0000};
    ref_mem[8'h91] = {32'h24450003, 32'h24450002, 32'h24450001, 32'h24450000};
    model_reset();

    bus.cpu_req_valid = 0; bus.cpu_req_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ack = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {bus.cpu_ready, bus.mem_req, bus.mem_we, bus.mem_addr, bus.cpu_rdata},
        {1'b0, 1'b0, 1'b0, 10'h0, 32'h0});
    chk("rst_counters", {hit_count, miss_count}, 160'(0));
    rst_n = 1'b1;

    // Directed table: cold fill, hit, write hit, dirty eviction with slow memory.
    for (int i = 0; i < 7; i++) begin
      model_step(vt[i].we, vt[i].addr, vt[i].wd);
      run_req(vt[i].we, vt[i].addr, vt[i].wd, vt[i].dly);
      chk("t_done", 160'(!timeout), 160'(1));
      chk("t_hit", 160'(got_hit), 160'(vt[i].hit));
      if (vt[i].hit) chk("t_latency", 160'(got_lat), 160'(2));
      chk("t_wb", 160'(wb_seen), 160'(vt[i].wb));
      if (vt[i].wb) begin
        chk("t_wb_addr", 160'(wb_addr), 160'(vt[i].wb_addr));
        chk("t_wb_word1", 160'(wb_data[63:32]), 160'(vt[i].wb_w1));
      end
      if (!vt[i].hit) chk("t_fill_addr", 160'(fill_addr), 160'(vt[i].fill_addr));
      chk("t_rdata", 160'(got_rdata), 160'(vt[i].rdata));
      chk("t_hits", 160'(hit_count), 160'(vt[i].hits));
      chk("t_misses", 160'(miss_count), 160'(vt[i].misses));
    end

    // Random traffic on a few conflicting lines against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic        we;
      logic [9:0]  a;
      logic [31:0] wd;
      int          dly;
      we  = 1'($urandom);
      a   = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom)};
      wd  = $urandom;
      dly = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 3));
      model_step(we, a, wd);
      run_req(we, a, wd, dly);
      check_model(we);
    end

    // Reset in the middle of a fill abandons the request.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    bus.cpu_req_valid = 1'b1; bus.cpu_req_we = 1'b0; bus.cpu_addr = 10'h200;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.cpu_req_valid = 1'b0;
      if (bus.mem_req) break;
    end
    chk("ra_alloc", {bus.mem_req, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 10'h200});
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("ra_idle", {bus.mem_req, bus.cpu_ready, bus.mem_addr, 2'(dut.state_q)},
        {1'b0, 1'b0, 10'h0, 2'(IDLE)});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ra_no_ready", {bus.cpu_ready, bus.mem_req}, 160'(0));
    end
    model_step(1'b0, 10'h200, 32'h0);
    run_req(1'b0, 10'h200, 32'h0, 1);
    check_model(1'b0);

    // Hit counter saturation.
    force dut.hit_count_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.hit_count_q;
    @(negedge clk);
    m_hits = 65535;
    chk("sat_preset", 160'(hit_count), 160'(16'hFFFF));
    model_step(1'b0, 10'h201, 32'h0);
    run_req(1'b0, 10'h201, 32'h0, 0);
    check_model(1'b0);
    chk("sat_hold", 160'(hit_count), 160'(16'hFFFF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
